// File: rtl/qspi_ctrl_pkg.sv
// qspi_ctrl_pkg: shared types and constants for the quad-SPI transaction engine.
//   qspi_target_e  - device selected by a request (flash or RAM)
//   qspi_state_e   - transaction FSM states
//   QSPI_CMD_*     - QPI command bytes
//   *Nibbles       - fixed phase lengths in nibble slots
package qspi_ctrl_pkg;

   typedef enum logic {
      TargetFlash = 1'b0,
      TargetRam   = 1'b1
   } qspi_target_e;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StDummy,
      StData,
      StDeselect
   } qspi_state_e;

   localparam logic [7:0] QSPI_CMD_READ  = 8'hEB;
   localparam logic [7:0] QSPI_CMD_WRITE = 8'h38;

   localparam int unsigned CmdNibbles  = 2;
   localparam int unsigned AddrNibbles = 6;
   localparam int unsigned DataNibbles = 2;

   // Slot counter width; covers every fixed phase and any sane dummy count.
   localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/qspi_ctrl_if.sv
// qspi_ctrl_if: request/response bus between the memory controller and qspi_ctrl.
//   start, is_write, target, addr, wdata - request from the memory controller
//   rdata, busy, done, error             - response from the transaction engine
// modport master: memory controller side; modport slave: qspi_ctrl side.
interface qspi_ctrl_if #(
   parameter int unsigned ADDRESS_WIDTH = 16
);
   import qspi_ctrl_pkg::*;

   logic                     start;
   logic                     is_write;
   qspi_target_e             target;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [7:0]               wdata;
   logic [7:0]               rdata;
   logic                     busy;
   logic                     done;
   logic                     error;

   modport master (
      output start, is_write, target, addr, wdata,
      input  rdata, busy, done, error
   );

   modport slave (
      input  start, is_write, target, addr, wdata,
      output rdata, busy, done, error
   );

endinterface

// File: rtl/qspi_shift_reg.sv
// qspi_shift_reg: 32-bit load / shift-left-by-nibble register.
//   clock, reset      - system clock, asynchronous active-low reset
//   load, load_value  - parallel load (has priority over shift)
//   shift, shift_in   - shift left by one nibble, shift_in enters at the bottom
//   nibble_out        - top nibble, the one currently on the wire
//   low_nibble        - bottom nibble, the most recently shifted-in value
module qspi_shift_reg (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        shift,
   input  logic [3:0]  shift_in,
   output logic [3:0]  nibble_out,
   output logic [3:0]  low_nibble
);

   logic [31:0] data_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= load_value;
      end else if (shift) begin
         data_q <= {data_q[27:0], shift_in};
      end
   end

   assign nibble_out = data_q[31:28];
   assign low_nibble = data_q[3:0];

endmodule

// File: rtl/qspi_ctrl.sv
// qspi_ctrl: turns one byte-wide request into a complete QPI transaction.
//   clock, reset      - system clock, asynchronous active-low reset
//   bus (slave)       - request/response handshake with the memory controller
//   spi_data_in       - IO0..IO3 from the device
//   spi_data_out/oe   - IO0..IO3 to the device and per-line output enable
//   spi_clk_out       - SPI clock at clock/2, idle low
//   spi_flash_select  - flash chip select, active low
//   spi_ram_a_select  - RAM chip select, active low
module qspi_ctrl
   import qspi_ctrl_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned FLASH_DUMMY   = 4,
   parameter int unsigned RAM_DUMMY     = 6
) (
   input  logic       clock,
   input  logic       reset,
   qspi_ctrl_if.slave bus,
   input  logic [3:0] spi_data_in,
   output logic [3:0] spi_data_out,
   output logic [3:0] spi_data_oe,
   output logic       spi_clk_out,
   output logic       spi_flash_select,
   output logic       spi_ram_a_select
);

   localparam logic [CntWidth-1:0] CmdLast  = CntWidth'(CmdNibbles - 1);
   localparam logic [CntWidth-1:0] AddrLast = CntWidth'(AddrNibbles - 1);
   localparam logic [CntWidth-1:0] DataLast = CntWidth'(DataNibbles - 1);

   qspi_state_e         state_q, state_d;
   logic                phase_q, phase_d;   // 0: SPI clock low half, 1: high half
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                is_write_q, is_write_d;
   qspi_target_e        target_q, target_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [7:0]          rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                sr_load;
   logic [31:0]         sr_load_value;
   logic                sr_shift;
   logic [3:0]          sr_shift_in;
   logic [3:0]          sr_nibble;
   logic [3:0]          sr_low;

   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic [7:0]               req_cmd;
   int unsigned              dummy_slots;
   logic [CntWidth-1:0]      last_cnt;
   logic                     slot_last;

   assign req_addr      = bus.addr;
   assign req_cmd       = bus.is_write ? QSPI_CMD_WRITE : QSPI_CMD_READ;
   assign sr_load_value = {req_cmd, 24'(req_addr)};
   assign dummy_slots   = (target_q == TargetFlash) ? FLASH_DUMMY : RAM_DUMMY;

   qspi_shift_reg u_shift_reg (
      .clock      (clock),
      .reset      (reset),
      .load       (sr_load),
      .load_value (sr_load_value),
      .shift      (sr_shift),
      .shift_in   (sr_shift_in),
      .nibble_out (sr_nibble),
      .low_nibble (sr_low)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         phase_q    <= 1'b0;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         target_q   <= TargetFlash;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         target_q   <= target_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   // Next-state logic. A slot ends on the high half of the SPI clock; that is
   // where the shift register advances and read nibbles are sampled.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      is_write_d  = is_write_q;
      target_d    = target_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_shift_in = spi_data_in;

      case (state_q)
         StCmd:   last_cnt = CmdLast;
         StAddr:  last_cnt = AddrLast;
         StDummy: last_cnt = CntWidth'(dummy_slots - 1);
         StData:  last_cnt = DataLast;
         default: last_cnt = '0;
      endcase
      slot_last = (cnt_q == last_cnt);

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.target == TargetFlash && bus.is_write) begin
                  err_d = 1'b1;
               end else begin
                  is_write_d = bus.is_write;
                  target_d   = bus.target;
                  wdata_d    = bus.wdata;
                  sr_load    = 1'b1;
                  phase_d    = 1'b0;
                  cnt_d      = '0;
                  state_d    = StCmd;
               end
            end
         end
         StCmd, StAddr, StDummy, StData: begin
            phase_d = ~phase_q;
            // The write byte rides in behind cmd+addr: the two nibbles shifted in
            // during CMD reach the top of the register exactly at the DATA phase.
            if (state_q == StCmd) begin
               sr_shift_in = (cnt_q == '0) ? wdata_q[7:4] : wdata_q[3:0];
            end
            if (phase_q) begin
               sr_shift = 1'b1;
               cnt_d    = slot_last ? '0 : cnt_q + CntWidth'(1);
               if (state_q == StData && !is_write_q && slot_last) begin
                  rdata_d = {sr_low, spi_data_in};
               end
               if (slot_last) begin
                  unique case (state_q)
                     StCmd:   state_d = StAddr;
                     StAddr:  state_d = (!is_write_q && dummy_slots != 0) ? StDummy : StData;
                     StDummy: state_d = StData;
                     default: state_d = StDeselect;
                  endcase
               end
            end
         end
         StDeselect: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Output logic, decoded from registered state only.
   always_comb begin
      spi_clk_out      = 1'b0;
      spi_data_oe      = 4'h0;
      spi_flash_select = 1'b1;
      spi_ram_a_select = 1'b1;

      unique case (state_q)
         StCmd, StAddr, StDummy, StData: begin
            spi_clk_out      = phase_q;
            spi_flash_select = (target_q != TargetFlash);
            spi_ram_a_select = (target_q != TargetRam);
            if (state_q == StCmd || state_q == StAddr || (state_q == StData && is_write_q)) begin
               spi_data_oe = 4'hF;
            end
         end
         default: ;
      endcase

      spi_data_out = (spi_data_oe == 4'hF) ? sr_nibble : 4'h0;
      bus.busy     = (state_q != StIdle);
      bus.done     = (state_q == StDeselect) || err_q;
      bus.error    = err_q;
      bus.rdata    = rdata_q;
   end

endmodule

// File: tb/tb_qspi_ctrl.sv
// tb_qspi_ctrl: scoreboard bench for qspi_ctrl. Stimulus pushes the expected
// completion and the expected per-slot pin state; two monitors pop and compare.
module tb_qspi_ctrl;
   import qspi_ctrl_pkg::*;

   typedef struct {
      int         cyc;
      logic       err;
      logic       busy;
      logic [7:0] rdata;
   } done_t;

   typedef struct {
      logic       sel_f;
      logic       sel_r;
      logic [3:0] oe;
      logic [3:0] out;
   } pin_t;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] spi_data_in = 4'h0;
   logic [3:0] spi_data_out, spi_data_oe;
   logic       spi_clk_out, spi_flash_select, spi_ram_a_select;

   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   done_t done_q[$];
   pin_t  pin_q[$];
   done_t mon_d;
   pin_t  mon_p;

   // Device model state.
   logic [7:0] dev_byte = 8'h00;
   int         dev_first = 99;
   int         dev_cnt = 0;

   qspi_ctrl_if #(.ADDRESS_WIDTH(16)) bus ();

   qspi_ctrl #(
      .ADDRESS_WIDTH (16),
      .FLASH_DUMMY   (4),
      .RAM_DUMMY     (6)
   ) dut (
      .clock            (clock),
      .reset            (rst_n),
      .bus              (bus),
      .spi_data_in      (spi_data_in),
      .spi_data_out     (spi_data_out),
      .spi_data_oe      (spi_data_oe),
      .spi_clk_out      (spi_clk_out),
      .spi_flash_select (spi_flash_select),
      .spi_ram_a_select (spi_ram_a_select)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Device: count slots from the low half of each SPI clock and drive the
   // response byte during the two data slots.
   always @(negedge clock) begin
      if (spi_flash_select && spi_ram_a_select) begin
         dev_cnt     = 0;
         spi_data_in = 4'h0;
      end else if (!spi_clk_out) begin
         if (dev_cnt == dev_first)          spi_data_in = dev_byte[7:4];
         else if (dev_cnt == dev_first + 1) spi_data_in = dev_byte[3:0];
         else                               spi_data_in = 4'hA;
         dev_cnt++;
      end
   end

   // Completion monitor.
   always @(negedge clock) begin
      if (rst_n && bus.done) begin
         if (done_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (cyc %0d)", cyc);
         end else begin
            mon_d = done_q.pop_front();
            chk("done_cycle", cyc, mon_d.cyc);
            chk("error", {31'd0, bus.error}, {31'd0, mon_d.err});
            chk("busy_at_done", {31'd0, bus.busy}, {31'd0, mon_d.busy});
            chk("rdata", {24'd0, bus.rdata}, {24'd0, mon_d.rdata});
            chk("pins_at_done",
                {21'd0, spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe, spi_data_out},
                {21'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});
         end
      end else if (rst_n && bus.error) begin
         chk("error_without_done", 32'd1, 32'd0);
      end
   end

   // Pin monitor: one sample per SPI clock high half.
   always @(negedge clock) begin
      if (rst_n && spi_clk_out) begin
         if (pin_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_slot: got spi_clk_out=1 expected idle (cyc %0d)", cyc);
         end else begin
            mon_p = pin_q.pop_front();
            chk("slot_pins",
                {22'd0, spi_flash_select, spi_ram_a_select, spi_data_oe, spi_data_out},
                {22'd0, mon_p.sel_f, mon_p.sel_r, mon_p.oe, mon_p.out});
         end
      end
   end

   task automatic push_pins(input logic w, input qspi_target_e t, input logic [15:0] a,
                            input logic [7:0] wd);
      logic [7:0]  cmd;
      logic [23:0] a24;
      pin_t        p;
      int          dmy;
      cmd     = w ? 8'h38 : 8'hEB;
      a24     = {8'h00, a};
      p.sel_f = (t == TargetFlash) ? 1'b0 : 1'b1;
      p.sel_r = ~p.sel_f;
      p.oe    = 4'hF;
      p.out   = cmd[7:4]; pin_q.push_back(p);
      p.out   = cmd[3:0]; pin_q.push_back(p);
      for (int i = 5; i >= 0; i--) begin
         p.out = a24[i*4 +: 4];
         pin_q.push_back(p);
      end
      if (w) begin
         p.out = wd[7:4]; pin_q.push_back(p);
         p.out = wd[3:0]; pin_q.push_back(p);
      end else begin
         dmy   = (t == TargetFlash) ? 4 : 6;
         p.oe  = 4'h0;
         p.out = 4'h0;
         for (int i = 0; i < dmy + 2; i++) pin_q.push_back(p);
      end
   endtask

   // Issue one request; a0 is the cycle number of its cycle 0.
   task automatic issue(input logic w, input qspi_target_e t, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] dev, input int lat,
                        input logic exp_err, input logic [7:0] exp_rd, output int a0);
      done_t d;
      int    n;
      n = 0;
      @(negedge clock);
      while (bus.busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      dev_byte     = dev;
      dev_first    = w ? 99 : ((t == TargetFlash) ? 12 : 14);
      bus.is_write = w;
      bus.target   = t;
      bus.addr     = a;
      bus.wdata    = wd;
      bus.start    = 1'b1;
      a0           = cyc;
      d.cyc        = cyc + lat;
      d.err        = exp_err;
      d.busy       = ~exp_err;
      d.rdata      = exp_rd;
      done_q.push_back(d);
      if (!exp_err) push_pins(w, t, a, wd);
      @(negedge clock);
      bus.start = 1'b0;
      // Scramble request inputs to show they were latched.
      bus.is_write = ~w;
      bus.addr     = 16'hFFFF;
      bus.wdata    = 8'h00;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((done_q.size() != 0 || pin_q.size() != 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (done_q.size() != 0 || pin_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0",
                  done_q.size(), pin_q.size());
      end
   endtask

   initial begin
      int    a0;
      done_t d;
      bus.start    = 1'b0;
      bus.is_write = 1'b0;
      bus.target   = TargetFlash;
      bus.addr     = '0;
      bus.wdata    = '0;
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);

      // Reset state.
      chk("reset_rdata", {24'd0, bus.rdata}, 32'd0);
      chk("reset_flags", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
      chk("reset_pins",
          {21'd0, spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe, spi_data_out},
          {21'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});

      // RAM write, RAM read, flash read, rejected flash write.
      issue(1'b1, TargetRam, 16'h1234, 8'hA5, 8'h00, 21, 1'b0, 8'h00, a0);
      drain();
      issue(1'b0, TargetRam, 16'h00FF, 8'h00, 8'h3C, 33, 1'b0, 8'h3C, a0);
      drain();
      issue(1'b0, TargetFlash, 16'hBEEF, 8'h00, 8'h96, 29, 1'b0, 8'h96, a0);
      drain();
      issue(1'b1, TargetFlash, 16'h0010, 8'h55, 8'h00, 1, 1'b1, 8'h96, a0);
      @(negedge clock);
      chk("flash_write_busy", {31'd0, bus.busy}, 32'd0);
      drain();

      // Back-to-back RAM writes with start held high.
      @(negedge clock);
      bus.is_write = 1'b1;
      bus.target   = TargetRam;
      bus.addr     = 16'h1234;
      bus.wdata    = 8'hA5;
      bus.start    = 1'b1;
      a0           = cyc;
      d.cyc = a0 + 21; d.err = 1'b0; d.busy = 1'b1; d.rdata = 8'h96;
      done_q.push_back(d);
      push_pins(1'b1, TargetRam, 16'h1234, 8'hA5);
      d.cyc = a0 + 43;
      done_q.push_back(d);
      push_pins(1'b1, TargetRam, 16'h5678, 8'h3C);
      while (cyc < a0 + 5) @(negedge clock);
      bus.addr  = 16'h5678;
      bus.wdata = 8'h3C;
      while (cyc < a0 + 22) @(negedge clock);
      chk("b2b_gap_pins", {30'd0, spi_flash_select, spi_ram_a_select}, 32'd3);
      chk("b2b_gap_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clock);
      bus.start = 1'b0;
      chk("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
      drain();

      // Reset during a RAM read.
      issue(1'b0, TargetRam, 16'h0200, 8'h00, 8'h11, 33, 1'b0, 8'h11, a0);
      while (cyc < a0 + 7) @(negedge clock);
      chk("pre_reset_ram_sel", {31'd0, spi_ram_a_select}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_pins",
          {21'd0, spi_flash_select, spi_ram_a_select, spi_clk_out, spi_data_oe, spi_data_out},
          {21'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0});
      chk("mid_reset_flags", {29'd0, bus.busy, bus.done, bus.error}, 32'd0);
      done_q.delete();
      pin_q.delete();
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      issue(1'b1, TargetRam, 16'h0042, 8'h7E, 8'h00, 21, 1'b0, 8'h00, a0);
      drain();
      issue(1'b0, TargetRam, 16'h0001, 8'h00, 8'hC3, 33, 1'b0, 8'hC3, a0);
      drain();
      repeat (4) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
